tap_controller: RTL and testbench



---
 rtl/tap_pkg.sv | 46 ++++
 rtl/tap_fsm.sv | 60 ++++++
 rtl/tap_controller.sv | 117 +++++++++++
 tb/tb_tap_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared types and constants for the boundary-scan TAP controller:
// state encodings, default instruction width/opcodes, capture pattern
// and the decoded per-state flags handed from the FSM to the datapath.
package tap_pkg;

    // Standard 1149.1 4-bit state encodings.
    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RUN_IDLE   = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_RESET      = 4'hF
    } tap_state_e;

    localparam int TAP_IR_LEN = 3;

    localparam logic [TAP_IR_LEN-1:0] TAP_OP_EXTEST = 3'b000;
    localparam logic [TAP_IR_LEN-1:0] TAP_OP_SAMPLE = 3'b001;
    localparam logic [TAP_IR_LEN-1:0] TAP_OP_BYPASS = 3'b111;

    // Two LSBs captured into the IR shift stage; upper bits are zero.
    localparam logic [1:0] TAP_IR_CAPTURE = 2'b01;

    // One-hot view of the states the datapath acts on.
    typedef struct packed {
        logic test_reset;
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
        logic capture_ir;
        logic shift_ir;
        logic update_ir;
    } tap_flags_t;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state machine: state register, next-state decode from TMS,
// and a flag decode of the current state for the datapath.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       TCLK,
    input  logic       RstBar,
    input  logic       TMS,
    output tap_state_e state,
    output tap_flags_t flags
);

    tap_state_e next_state;

    // State register; reset forces Test-Logic-Reset.
    always_ff @(posedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            state <= TAP_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode following the 1149.1 state diagram.
    always_comb begin
        next_state = state;
        case (state)
            TAP_RESET:      next_state = TMS ? TAP_RESET     : TAP_RUN_IDLE;
            TAP_RUN_IDLE:   next_state = TMS ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_DR:  next_state = TMS ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: next_state = TMS ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   next_state = TMS ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   next_state = TMS ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   next_state = TMS ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   next_state = TMS ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  next_state = TMS ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_IR:  next_state = TMS ? TAP_RESET     : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: next_state = TMS ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   next_state = TMS ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   next_state = TMS ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   next_state = TMS ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   next_state = TMS ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  next_state = TMS ? TAP_SELECT_DR : TAP_RUN_IDLE;
            default:        next_state = TAP_RESET;
        endcase
    end

    // Output decode: flag the states the IR/DR datapath reacts to.
    always_comb begin
        flags            = '0;
        flags.test_reset = (state == TAP_RESET);
        flags.capture_dr = (state == TAP_CAPTURE_DR);
        flags.shift_dr   = (state == TAP_SHIFT_DR);
        flags.update_dr  = (state == TAP_UPDATE_DR);
        flags.capture_ir = (state == TAP_CAPTURE_IR);
        flags.shift_ir   = (state == TAP_SHIFT_IR);
        flags.update_ir  = (state == TAP_UPDATE_IR);
    end

endmodule

// File: rtl/tap_controller.sv
// Boundary-scan TAP controller: instruction register, bypass bit,
// chain strobe decode and TDO source selection around the TAP FSM.
// TapState exposes the FSM state for debug.
module tap_controller
    import tap_pkg::*;
#(
    parameter int                 IR_LEN    = TAP_IR_LEN,
    parameter logic [IR_LEN-1:0]  OP_EXTEST = IR_LEN'(TAP_OP_EXTEST),
    parameter logic [IR_LEN-1:0]  OP_SAMPLE = IR_LEN'(TAP_OP_SAMPLE),
    parameter logic [IR_LEN-1:0]  OP_BYPASS = IR_LEN'(TAP_OP_BYPASS)
) (
    input  logic       TCLK,
    input  logic       RstBar,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSR_SO,
    output logic       TDO,
    output logic       TDO_en,
    output logic       ShiftBR,
    output logic       ClockBR,
    output logic       UpdateBR,
    output logic       ModeControl,
    output logic [3:0] TapState
);

    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(TAP_IR_CAPTURE);

    tap_state_e        state;
    tap_flags_t        flags;
    logic [IR_LEN-1:0] ir_sh;
    logic [IR_LEN-1:0] ir_reg;
    logic              bypass_q;
    logic              bsr_sel;
    logic              tdo_q;
    logic              tdo_en_q;
    logic              tdo_next;

    tap_fsm u_fsm (
        .TCLK   (TCLK),
        .RstBar (RstBar),
        .TMS    (TMS),
        .state  (state),
        .flags  (flags)
    );

    assign TapState = state;
    assign TDO      = tdo_q;
    assign TDO_en   = tdo_en_q;

    // EXTEST and SAMPLE route the DR path through the boundary-scan chain;
    // any other opcode behaves as BYPASS.
    assign bsr_sel = (ir_reg == OP_EXTEST) || (ir_reg == OP_SAMPLE);

    // IR shift stage: capture the fixed pattern, then shift right with TDI at the MSB.
    always_ff @(posedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            ir_sh <= '0;
        end else if (flags.capture_ir) begin
            ir_sh <= IR_CAPTURE;
        end else if (flags.shift_ir) begin
            ir_sh <= {TDI, ir_sh[IR_LEN-1:1]};
        end
    end

    // Bypass bit: cleared in Capture-DR, loads TDI in Shift-DR only when bypassing.
    always_ff @(posedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            bypass_q <= 1'b0;
        end else if (flags.capture_dr) begin
            bypass_q <= 1'b0;
        end else if (flags.shift_dr && !bsr_sel) begin
            bypass_q <= TDI;
        end
    end

    // IR update stage on the falling edge so ModeControl moves mid-cycle;
    // Test-Logic-Reset forces BYPASS.
    always_ff @(negedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            ir_reg <= OP_BYPASS;
        end else if (flags.test_reset) begin
            ir_reg <= OP_BYPASS;
        end else if (flags.update_ir) begin
            ir_reg <= ir_sh;
        end
    end

    // Select the serial source for TDO; hold the last bit outside shift states.
    always_comb begin
        tdo_next = tdo_q;
        if (flags.shift_ir) begin
            tdo_next = ir_sh[0];
        end else if (flags.shift_dr) begin
            tdo_next = bsr_sel ? BSR_SO : bypass_q;
        end
    end

    // TDO and its enable launch on the falling edge.
    always_ff @(negedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_next;
            tdo_en_q <= flags.shift_ir | flags.shift_dr;
        end
    end

    // Chain strobes decoded from the registered state and current instruction.
    always_comb begin
        ClockBR     = ~(bsr_sel & (flags.capture_dr | flags.shift_dr));
        ShiftBR     = flags.shift_dr;
        UpdateBR    = bsr_sel & flags.update_dr;
        ModeControl = (ir_reg == OP_EXTEST);
    end

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: a reference TAP state sequence,
// per-cycle strobe checks and a TDO scoreboard fed at stimulus time.
module tb_tap_controller;

    localparam logic [3:0] S_TLR   = 4'hF, S_RTI   = 4'hC, S_SELDR = 4'h7,
                           S_CAPDR = 4'h6, S_SHDR  = 4'h2, S_EX1DR = 4'h1,
                           S_PDR   = 4'h3, S_EX2DR = 4'h0, S_UPDDR = 4'h5,
                           S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR  = 4'hA,
                           S_EX1IR = 4'h9, S_PIR   = 4'hB, S_EX2IR = 4'h8,
                           S_UPDIR = 4'hD;

    localparam logic [2:0] OP_EXTEST = 3'b000;
    localparam logic [2:0] OP_SAMPLE = 3'b001;
    localparam logic [2:0] OP_BYPASS = 3'b111;

    logic       TCLK = 1'b0;
    logic       RstBar;
    logic       TMS;
    logic       TDI;
    logic       BSR_SO;
    logic       TDO;
    logic       TDO_en;
    logic       ShiftBR;
    logic       ClockBR;
    logic       UpdateBR;
    logic       ModeControl;
    logic [3:0] TapState;

    logic [0:0] exp_q[$];
    logic [3:0] m_state;
    logic [2:0] m_ir;
    int         n_checks;
    int         n_pass;
    int         n_upd;
    int         n_shift_edges;

    tap_controller dut (
        .TCLK        (TCLK),
        .RstBar      (RstBar),
        .TMS         (TMS),
        .TDI         (TDI),
        .BSR_SO      (BSR_SO),
        .TDO         (TDO),
        .TDO_en      (TDO_en),
        .ShiftBR     (ShiftBR),
        .ClockBR     (ClockBR),
        .UpdateBR    (UpdateBR),
        .ModeControl (ModeControl),
        .TapState    (TapState)
    );

    // Clock: 10 time-unit period.
    always #5 TCLK = ~TCLK;

    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic tms);
        case (s)
            S_TLR:   return tms ? S_TLR   : S_RTI;
            S_RTI:   return tms ? S_SELDR : S_RTI;
            S_SELDR: return tms ? S_SELIR : S_CAPDR;
            S_CAPDR: return tms ? S_EX1DR : S_SHDR;
            S_SHDR:  return tms ? S_EX1DR : S_SHDR;
            S_EX1DR: return tms ? S_UPDDR : S_PDR;
            S_PDR:   return tms ? S_EX2DR : S_PDR;
            S_EX2DR: return tms ? S_UPDDR : S_SHDR;
            S_UPDDR: return tms ? S_SELDR : S_RTI;
            S_SELIR: return tms ? S_TLR   : S_CAPIR;
            S_CAPIR: return tms ? S_EX1IR : S_SHIR;
            S_SHIR:  return tms ? S_EX1IR : S_SHIR;
            S_EX1IR: return tms ? S_UPDIR : S_PIR;
            S_PIR:   return tms ? S_EX2IR : S_PIR;
            S_EX2IR: return tms ? S_UPDIR : S_SHIR;
            default: return tms ? S_SELDR : S_RTI;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle checks after the falling edge; TDO pops the scoreboard.
    task automatic monitor();
        logic       bsr_m;
        logic [0:0] exp_bit;
        bsr_m = (m_ir == OP_EXTEST) || (m_ir == OP_SAMPLE);
        check("tap_state", TapState, m_state);
        check("clock_br", ClockBR, !(bsr_m && (m_state == S_CAPDR || m_state == S_SHDR)));
        check("shift_br", ShiftBR, m_state == S_SHDR);
        check("update_br", UpdateBR, bsr_m && m_state == S_UPDDR);
        check("mode_control", ModeControl, m_ir == OP_EXTEST);
        check("tdo_en", TDO_en, m_state == S_SHDR || m_state == S_SHIR);
        if (UpdateBR) n_upd++;
        if (TDO_en) begin
            if (exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                check("tdo", TDO, exp_bit);
            end else begin
                check("tdo_unexpected", TDO_en, 1'b0);
            end
        end
    endtask

    // One TCLK cycle: drive inputs in the low phase, push the expected TDO
    // bit if the cycle lands in a shift state, then check after the negedge.
    task automatic step(input logic tms, input logic tdi, input logic so, input logic exp_tdo);
        logic [3:0] nxt;
        nxt = ref_next(m_state, tms);
        if (nxt == S_SHDR || nxt == S_SHIR) exp_q.push_back(exp_tdo);
        TMS    = tms;
        TDI    = tdi;
        BSR_SO = so;
        if (ShiftBR && !ClockBR) n_shift_edges++;
        @(posedge TCLK);
        @(negedge TCLK);
        #1;
        m_state = nxt;
        if (m_state == S_TLR) m_ir = OP_BYPASS;
        monitor();
    endtask

    // From Run-Test/Idle: load an instruction LSB first, back to Run-Test/Idle.
    task automatic load_ir(input logic [2:0] val);
        logic [3:0] cap;
        cap = 4'b0001;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, cap[0]);
        for (int i = 0; i < 3; i++) begin
            step(i == 2, val[i], 1'b0, cap[i+1]);
        end
        m_ir = val;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: DR scan through the bypass bit; TDO lags TDI by one bit.
    task automatic dr_scan_bypass(input int n, input logic [15:0] bits);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(1'b0, bits[i], 1'b0, bits[i]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic so;
        logic tms;
        n_checks = 0;
        n_pass   = 0;
        n_upd    = 0;
        TMS      = 1'b1;
        TDI      = 1'b0;
        BSR_SO   = 1'b0;
        RstBar   = 1'b1;
        m_state  = S_TLR;
        m_ir     = OP_BYPASS;

        // Reset values under asynchronous reset.
        #1 RstBar = 1'b0;
        #2;
        check("rst_state", TapState, S_TLR);
        check("rst_clock_br", ClockBR, 1'b1);
        check("rst_shift_br", ShiftBR, 1'b0);
        check("rst_update_br", UpdateBR, 1'b0);
        check("rst_mode", ModeControl, 1'b0);
        check("rst_tdo", TDO, 1'b0);
        check("rst_tdo_en", TDO_en, 1'b0);
        #9 RstBar = 1'b1;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // EXTEST load: TDO shows the captured 1,0,0; ModeControl rises at Update-IR.
        load_ir(OP_EXTEST);

        // EXTEST 8-bit chain shift with a Pause-DR in the middle.
        n_shift_edges = 0;
        n_upd         = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        so = 1'($urandom_range(0, 1));
        step(1'b0, 1'($urandom_range(0, 1)), so, so);
        for (int k = 0; k < 8; k++) begin
            tms = (k == 3) || (k == 7);
            so  = 1'($urandom_range(0, 1));
            step(tms, 1'($urandom_range(0, 1)), so, so);
            if (k == 3) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b0, 1'b0, 1'b0);
                step(1'b1, 1'b0, 1'b0, 1'b0);
                so = 1'($urandom_range(0, 1));
                step(1'b0, 1'($urandom_range(0, 1)), so, so);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("extest_shift_edges", n_shift_edges, 8);
        check("extest_update_pulses", n_upd, 1);

        // SAMPLE capture: one cycle of ClockBR low with ShiftBR low.
        load_ir(OP_SAMPLE);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Undefined opcode decodes as BYPASS: TDI 1,1,0,1 -> TDO 0,1,1,0,1.
        load_ir(3'b101);
        n_upd = 0;
        dr_scan_bypass(4, 16'b1011);
        check("bypass_no_update", n_upd, 0);

        // Five TMS=1 clocks from Shift-DR reach Test-Logic-Reset.
        load_ir(OP_EXTEST);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("tms_reset_state", TapState, S_TLR);
        check("tms_reset_mode", ModeControl, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Default BYPASS after reset with random data.
        dr_scan_bypass(8, 16'($urandom_range(0, 255)));

        // Asynchronous reset in the middle of an EXTEST shift.
        load_ir(OP_EXTEST);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        n_upd = 0;
        #2 RstBar = 1'b0;
        #1;
        check("arst_state", TapState, S_TLR);
        check("arst_clock_br", ClockBR, 1'b1);
        check("arst_shift_br", ShiftBR, 1'b0);
        check("arst_update_br", UpdateBR, 1'b0);
        check("arst_mode", ModeControl, 1'b0);
        check("arst_tdo", TDO, 1'b0);
        check("arst_tdo_en", TDO_en, 1'b0);
        repeat (3) begin
            @(negedge TCLK);
            #1;
            if (UpdateBR) n_upd++;
        end
        RstBar  = 1'b1;
        m_state = S_TLR;
        m_ir    = OP_BYPASS;
        check("arst_no_update", n_upd, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        dr_scan_bypass(4, 16'($urandom_range(0, 15)));

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
